// File: rtl/fifo_read_arbiter_if.sv
// Handshake/bus bundle between the fifo read arbiter, the fifo read ports
// and the downstream consumer. master = arbiter side, slave = environment.
interface fifo_read_arbiter_if #(
  parameter int N_CH     = 4,
  parameter int DATA_LEN = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]          i_chan_en;
  logic [N_CH-1:0]          i_empty_n;
  logic [N_CH*DATA_LEN-1:0] i_fifo_data;
  logic [N_CH-1:0]          i_read_error;
  logic [N_CH-1:0]          o_read;
  logic [DATA_LEN-1:0]      o_data;
  logic [CH_W-1:0]          o_channel;
  logic                     o_valid;
  logic                     i_ready;
  logic [N_CH-1:0]          o_error;
  logic                     i_error_clr;

  modport master (
    input  i_chan_en, i_empty_n, i_fifo_data, i_read_error, i_ready, i_error_clr,
    output o_read, o_data, o_channel, o_valid, o_error
  );

  modport slave (
    output i_chan_en, i_empty_n, i_fifo_data, i_read_error, i_ready, i_error_clr,
    input  o_read, o_data, o_channel, o_valid, o_error
  );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin read scheduler draining N_CH fifos onto one valid/ready stream.
// One read outstanding at a time: IDLE -> ISSUE (strobe) -> WAIT (capture) -> OUT.
// Optional feature macro: FIFO_ARB_BURST_EN (up to BURST_LEN words per grant).
module fifo_read_arbiter #(
  parameter int N_CH      = 4,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                 i_clk_read,
  input  logic                 i_reset,
  fifo_read_arbiter_if.master  bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Reject out-of-range configurations at elaboration.
  if (N_CH < 2 || N_CH > 16) begin : g_bad_n_ch
    $error("fifo_read_arbiter: N_CH must be 2..16");
  end
  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("fifo_read_arbiter: BURST_LEN must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t              r_state,   w_state_nx;
  logic [CH_W-1:0]     r_grant,   w_grant_nx;
  logic [CH_W-1:0]     r_last,    w_last_nx;
  logic [N_CH-1:0]     r_read,    w_read_nx;
  logic [N_CH-1:0]     r_error,   w_error_nx;
  logic [DATA_LEN-1:0] r_data,    w_data_nx;
  logic [CH_W-1:0]     r_channel, w_channel_nx;
  logic                r_valid,   w_valid_nx;

  logic [N_CH-1:0]     w_req;
  logic [CH_W-1:0]     w_rr_base;
  logic [CH_W-1:0]     w_rr_pick;
  logic                w_rr_found;
  int unsigned         w_idx;

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic             r_hold, w_hold_nx;
  logic [CNT_W-1:0] r_cnt,  w_cnt_nx;

  // While a burst is held open the search base is the held channel, so a
  // burst ending in IDLE rotates exactly as if last_grant had been updated.
  assign w_rr_base = r_hold ? r_grant : r_last;
`else
  assign w_rr_base = r_last;
`endif

  assign w_req = bus.i_chan_en & bus.i_empty_n;

  // Round-robin search: first requesting channel after the base, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = '0;
    w_idx      = 0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      w_idx = (int'(w_rr_base) + off) % N_CH;
      if (!w_rr_found && w_req[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = CH_W'(w_idx);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_last_nx    = r_last;
    w_read_nx    = '0;
    w_data_nx    = r_data;
    w_channel_nx = r_channel;
    w_valid_nx   = r_valid;
    w_error_nx   = bus.i_error_clr ? '0 : r_error;
`ifdef FIFO_ARB_BURST_EN
    w_hold_nx    = r_hold;
    w_cnt_nx     = r_cnt;
`endif
    case (r_state)
      IDLE: begin
`ifdef FIFO_ARB_BURST_EN
        if (r_hold && w_req[r_grant]) begin
          w_read_nx[r_grant] = 1'b1;
          w_state_nx         = ISSUE;
        end else begin
          if (r_hold) begin
            w_hold_nx = 1'b0;
            w_cnt_nx  = '0;
            w_last_nx = r_grant;
          end
          if (w_rr_found) begin
            w_grant_nx           = w_rr_pick;
            w_read_nx[w_rr_pick] = 1'b1;
            w_cnt_nx             = '0;
            w_state_nx           = ISSUE;
          end
        end
`else
        if (w_rr_found) begin
          w_grant_nx           = w_rr_pick;
          w_read_nx[w_rr_pick] = 1'b1;
          w_state_nx           = ISSUE;
        end
`endif
      end
      ISSUE: begin
        w_state_nx = WAIT;
      end
      WAIT: begin
        if (bus.i_read_error[r_grant]) begin
          w_error_nx[r_grant] = 1'b1;
          w_last_nx           = r_grant;
          w_state_nx          = IDLE;
`ifdef FIFO_ARB_BURST_EN
          w_hold_nx           = 1'b0;
          w_cnt_nx            = '0;
`endif
        end else begin
          w_data_nx    = bus.i_fifo_data[r_grant*DATA_LEN +: DATA_LEN];
          w_channel_nx = r_grant;
          w_valid_nx   = 1'b1;
          w_state_nx   = OUT;
        end
      end
      OUT: begin
        if (bus.i_ready) begin
          w_valid_nx = 1'b0;
          w_state_nx = IDLE;
`ifdef FIFO_ARB_BURST_EN
          if ((r_cnt + 1'b1) < CNT_W'(BURST_LEN)) begin
            w_hold_nx = 1'b1;
            w_cnt_nx  = r_cnt + 1'b1;
          end else begin
            w_hold_nx = 1'b0;
            w_cnt_nx  = '0;
            w_last_nx = r_grant;
          end
`else
          w_last_nx  = r_grant;
`endif
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk_read) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= CH_W'(N_CH - 1);
      r_read    <= '0;
      r_data    <= '0;
      r_channel <= '0;
      r_valid   <= 1'b0;
      r_error   <= '0;
`ifdef FIFO_ARB_BURST_EN
      r_hold    <= 1'b0;
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_last    <= w_last_nx;
      r_read    <= w_read_nx;
      r_data    <= w_data_nx;
      r_channel <= w_channel_nx;
      r_valid   <= w_valid_nx;
      r_error   <= w_error_nx;
`ifdef FIFO_ARB_BURST_EN
      r_hold    <= w_hold_nx;
      r_cnt     <= w_cnt_nx;
`endif
    end
  end

  assign bus.o_read    = r_read;
  assign bus.o_data    = r_data;
  assign bus.o_channel = r_channel;
  assign bus.o_valid   = r_valid;
  assign bus.o_error   = r_error;
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: emulated fifos, a transaction-level model,
// a per-channel data scoreboard and directed literal checks.
module tb_fifo_read_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_read_arbiter_if #(.N_CH(N), .DATA_LEN(DW)) bus ();

  fifo_read_arbiter #(.N_CH(N), .DATA_LEN(DW), .BURST_LEN(BL)) dut (
    .i_clk_read (clk),
    .i_reset    (rst),
    .bus        (bus.master)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit started = 1'b0;

  logic [DW-1:0] fq    [N][$];
  logic [DW-1:0] exp_q [N][$];
  int force_err_ch = -1;
  int err_rate     = 0;

  // Model state
  int            m_phase;
  int            m_g;
  int            m_last;
  logic [N-1:0]  m_read;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_chan;
  logic [N-1:0]  m_err;
  bit            m_hold;
  int            m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) bus.i_empty_n[k] = (fq[k].size() != 0);
  endtask

  task automatic push(input int k, input logic [DW-1:0] v);
    fq[k].push_back(v);
    refresh();
  endtask

  // Fifo read ports: a strobe seen here pops a word onto that channel's output.
  task automatic service();
    logic [DW-1:0] w;
    bit bad;
    for (int k = 0; k < N; k++) begin
      if (bus.o_read[k]) begin
        bad = (fq[k].size() == 0) || (force_err_ch == k) ||
              (err_rate != 0 && $urandom_range(0, err_rate - 1) == 0);
        if (force_err_ch == k) force_err_ch = -1;
        w = '0;
        if (fq[k].size() != 0) w = fq[k].pop_front();
        if (bad) w = DW'($urandom);
        bus.i_fifo_data[k*DW +: DW] = w;
        bus.i_read_error[k] = bad;
        if (!bad) exp_q[k].push_back(w);
      end
    end
    refresh();
  endtask

  task automatic tick();
    @(negedge clk);
    service();
  endtask

  task automatic clear_fifos();
    for (int k = 0; k < N; k++) fq[k].delete();
    bus.i_fifo_data  = '0;
    bus.i_read_error = '0;
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_fifos();
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
  endtask

  task automatic wait_grant(output int ch);
    ch = -1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (bus.o_read != '0) begin
        ch = $clog2(bus.o_read);
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (bus.o_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Behavioural model: one word per grant, advanced on each clock edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_g = 0; m_last = N - 1; m_read = '0; m_valid = 1'b0;
        m_data = '0; m_chan = 0; m_err = '0; m_hold = 1'b0; m_cnt = 0;
        for (int k = 0; k < N; k++) exp_q[k].delete();
      end else begin
        logic [N-1:0] req;
        logic [N-1:0] nerr;
        int g;
        nerr   = bus.i_error_clr ? '0 : m_err;
        m_read = '0;
        req    = bus.i_chan_en & bus.i_empty_n;
        g      = -1;
        case (m_phase)
          0: begin
`ifdef FIFO_ARB_BURST_EN
            if (m_hold && req[m_g]) g = m_g;
            else if (m_hold) begin
              m_last = m_g; m_hold = 1'b0; m_cnt = 0;
            end
            if (g < 0) begin
              for (int j = 1; j <= N; j++)
                if (req[(m_last + j) % N]) begin g = (m_last + j) % N; m_cnt = 0; break; end
            end
`else
            for (int j = 1; j <= N; j++)
              if (req[(m_last + j) % N]) begin g = (m_last + j) % N; break; end
`endif
            if (g >= 0) begin
              m_g = g; m_read[g] = 1'b1; m_phase = 1;
            end
          end
          1: m_phase = 2;
          2: begin
            if (bus.i_read_error[m_g]) begin
              nerr[m_g] = 1'b1; m_last = m_g; m_hold = 1'b0; m_cnt = 0; m_phase = 0;
            end else begin
              m_valid = 1'b1; m_data = bus.i_fifo_data[m_g*DW +: DW]; m_chan = m_g; m_phase = 3;
            end
          end
          default: begin
            if (bus.i_ready) begin
              if (exp_q[m_chan].size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
              else check("scoreboard_data", 32'(m_data), 32'(exp_q[m_chan].pop_front()));
              m_valid = 1'b0; m_phase = 0;
`ifdef FIFO_ARB_BURST_EN
              m_cnt++;
              if (m_cnt < BL) m_hold = 1'b1;
              else begin m_hold = 1'b0; m_cnt = 0; m_last = m_g; end
`else
              m_last = m_g;
`endif
            end
          end
        endcase
        m_err = nerr;
      end
    end
  end

  // Cycle compare of DUT against the model, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        bit ok;
        ok = (bus.o_read === m_read) && (bus.o_valid === m_valid) && (bus.o_error === m_err) &&
             (!m_valid || (bus.o_data === m_data && bus.o_channel === 2'(m_chan)));
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL cycle: got read=%b valid=%b data=%h ch=%0d err=%b, expected read=%b valid=%b data=%h ch=%0d err=%b at %0t",
                      bus.o_read, bus.o_valid, bus.o_data, bus.o_channel, bus.o_error,
                      m_read, m_valid, m_data, m_chan, m_err, $time);
        check("read_onehot", 32'($countones(bus.o_read) <= 1), 32'd1);
      end
    end
  end

  initial begin
    int ch;
    bit seen;
    bus.i_chan_en = '1; bus.i_empty_n = '0; bus.i_fifo_data = '0; bus.i_read_error = '0;
    bus.i_ready = 1'b1; bus.i_error_clr = 1'b0;

    // Reset state and single word on ch0
    do_reset();
    check("rst_read", 32'(bus.o_read), 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_data", 32'(bus.o_data), 32'h0);
    check("rst_chan", 32'(bus.o_channel), 32'h0);
    check("rst_error", 32'(bus.o_error), 32'h0);
    push(0, 8'hA5);
    tick();
    check("t1_read", 32'(bus.o_read), 32'h1);
    tick();
    check("t1_read_off", 32'(bus.o_read), 32'h0);
    check("t1_valid_wait", 32'(bus.o_valid), 32'h0);
    tick();
    check("t1_valid", 32'(bus.o_valid), 32'h1);
    check("t1_data", 32'(bus.o_data), 32'hA5);
    check("t1_chan", 32'(bus.o_channel), 32'h0);
    check("t1_error", 32'(bus.o_error), 32'h0);
    tick();
    check("t1_accepted", 32'(bus.o_valid), 32'h0);

    // Round-robin order over all channels
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) push(k, 8'(16 * r + k));
      for (int i = 0; i < N; i++) begin
        wait_grant(ch);
        check("rr_order", 32'(ch), 32'(i));
      end
    end
    repeat (6) tick();

    // Back-pressure hold
    do_reset();
    bus.i_ready = 1'b0;
    push(1, 8'h3C);
    wait_valid(seen);
    check("bp_seen", 32'(seen), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(bus.o_valid), 32'h1);
      check("bp_data", 32'(bus.o_data), 32'h3C);
      check("bp_chan", 32'(bus.o_channel), 32'h1);
      check("bp_read", 32'(bus.o_read), 32'h0);
    end
    bus.i_ready = 1'b1;
    tick();
    check("bp_accept", 32'(bus.o_valid), 32'h0);

    // Read error on ch2
    do_reset();
    bus.i_chan_en = 4'b1100;
    push(2, 8'h11);
    push(3, 8'h22);
    force_err_ch = 2;
    wait_grant(ch);
    check("err_grant", 32'(ch), 32'd2);
    tick();
    tick();
    check("err_no_valid", 32'(bus.o_valid), 32'h0);
    check("err_flag", 32'(bus.o_error), 32'b0100);
    wait_grant(ch);
    check("err_next", 32'(ch), 32'd3);
    bus.i_error_clr = 1'b1;
    tick();
    bus.i_error_clr = 1'b0;
    check("err_clr", 32'(bus.o_error), 32'h0);
    repeat (6) tick();

    // Channel enable mask
    do_reset();
    bus.i_chan_en = 4'b1010;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) push(k, 8'(8'h40 + k));
      wait_grant(ch);
      check("mask_a", 32'(ch), 32'd1);
      wait_grant(ch);
      check("mask_b", 32'(ch), 32'd3);
    end
    repeat (6) tick();

    // Reset during OUT
    do_reset();
    bus.i_chan_en = '1;
    bus.i_ready = 1'b0;
    push(1, 8'h77);
    wait_valid(seen);
    check("rst_out_seen", 32'(seen), 32'h1);
    rst = 1'b1;
    tick();
    check("rst_out_valid", 32'(bus.o_valid), 32'h0);
    check("rst_out_read", 32'(bus.o_read), 32'h0);
    do_reset();
    bus.i_ready = 1'b1;
    push(2, 8'h55);
    push(0, 8'h66);
    wait_grant(ch);
    check("rst_first_grant", 32'(ch), 32'd0);
    repeat (10) tick();

`ifdef FIFO_ARB_BURST_EN
    // Burst: ch1 holds 6 words, ch2 one
    do_reset();
    bus.i_chan_en = 4'b0110;
    for (int i = 0; i < 6; i++) push(1, 8'(i));
    push(2, 8'hEE);
    begin
      int exp_seq [7] = '{1, 1, 1, 1, 2, 1, 1};
      for (int i = 0; i < 7; i++) begin
        wait_grant(ch);
        check("burst_order", 32'(ch), 32'(exp_seq[i]));
      end
    end
    repeat (6) tick();
`endif

    // Randomized traffic with errors, back-pressure and enable changes
    do_reset();
    err_rate = 8;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        if (fq[k].size() < 6) push(k, DW'($urandom));
      end
      if ($urandom_range(0, 15) == 0) bus.i_chan_en = N'($urandom);
      bus.i_ready     = ($urandom_range(0, 3) != 0);
      bus.i_error_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    err_rate = 0;
    bus.i_error_clr = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_chan_en = '1;
    repeat (120) tick();
    begin
      int left;
      left = 0;
      for (int k = 0; k < N; k++) left += fq[k].size() + exp_q[k].size();
      check("drained", 32'(left), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
